// File: rtl/osd_glyph_fetch.sv
// -----------------------------------------------------------------------------
// osd_glyph_fetch
//
// Read-side master for the OSD character ROM. Takes (character code, glyph
// row) requests from the text layout logic, issues one ROM read per request,
// absorbs the ROM read latency and serializes each returned glyph row MSB
// first into a 1-bit-per-pixel valid/ready stream for the overlay mixer.
//
// Build option:
//   OSD_GLYPH_INVERT_EN  when defined, req_inv travels with each read and the
//                        row's pixels are inverted (highlight / cursor rows).
//                        When undefined, req_inv is ignored and not stored.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   req_valid/ready request handshake (ready depends on state only)
//   req_code        character code
//   req_row         glyph row
//   req_inv         invert this row (OSD_GLYPH_INVERT_EN only)
//   rom_addr        registered ROM address {code, row}
//   rom_rd_en       registered one-cycle ROM read strobe
//   rom_rd_data     ROM read data, valid ROM_LATENCY cycles after the strobe
//   pix_valid/ready pixel stream handshake
//   pix_data        current pixel, MSB of the glyph row first
//   pix_last        last pixel of a glyph row
//
// ROM_ADDR_W must equal CODE_W + ROW_W; ROM_LATENCY is 1 or 2.
// -----------------------------------------------------------------------------
module osd_glyph_fetch #(
    parameter int CODE_W      = 7,
    parameter int ROW_W       = 4,
    parameter int ROM_ADDR_W  = 11,
    parameter int GLYPH_W     = 8,
    parameter int ROM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [CODE_W-1:0]     req_code,
    input  logic [ROW_W-1:0]      req_row,
    input  logic                  req_inv,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    output logic                  rom_rd_en,
    input  logic [GLYPH_W-1:0]    rom_rd_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  pix_data,
    output logic                  pix_last
);

    localparam int               CNT_W    = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GLYPH_W - 1);

    // Credits in use: reads in flight plus occupied word slots (max 2).
    logic [1:0]             used;
    logic [1:0]             used_nxt;

    // One valid bit per ROM pipeline stage; the top bit marks the cycle in
    // which rom_rd_data belongs to one of our reads.
    logic [ROM_LATENCY-1:0] tag_vld;

    logic [GLYPH_W-1:0]     shift_word;
    logic [GLYPH_W-1:0]     spare_word;
    logic                   shift_full;
    logic                   spare_full;
    logic [CNT_W-1:0]       cnt;

    logic                   accept;
    logic                   pix_fire;
    logic                   release_row;
    logic                   capture;
    logic                   cap_inv;
    logic [GLYPH_W-1:0]     cap_word;

    assign accept      = req_valid & req_ready;
    assign pix_fire    = shift_full & pix_ready;
    assign release_row = pix_fire & (cnt == CNT_LAST);
    assign capture     = tag_vld[ROM_LATENCY-1];

    // Inversion is folded in at capture time, so the slots hold final pixels.
    assign cap_word = rom_rd_data ^ {GLYPH_W{cap_inv}};

    assign used_nxt = used + 2'(accept) - 2'(release_row);

    assign pix_valid = shift_full;
    assign pix_data  = shift_word[CNT_LAST - cnt];
    assign pix_last  = (cnt == CNT_LAST);

`ifdef OSD_GLYPH_INVERT_EN
    // Invert flag follows its read through the same stages as tag_vld.
    logic                   rd_inv;
    logic [ROM_LATENCY-1:0] tag_inv;

    assign cap_inv = tag_inv[ROM_LATENCY-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_inv  <= 1'b0;
            tag_inv <= '0;
        end else begin
            if (accept) begin
                rd_inv <= req_inv;
            end
            tag_inv[0] <= rd_inv;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                tag_inv[i] <= tag_inv[i-1];
            end
        end
    end
`else
    logic unused_inv;

    assign cap_inv    = 1'b0;
    assign unused_inv = req_inv;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            used       <= '0;
            req_ready  <= 1'b0;
            rom_addr   <= '0;
            rom_rd_en  <= 1'b0;
            tag_vld    <= '0;
            // NOTE: the slot words are reset, not just their full flags, so
            // pix_data reads 0 during and right after reset.
            shift_word <= '0;
            spare_word <= '0;
            shift_full <= 1'b0;
            spare_full <= 1'b0;
            cnt        <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout; every right-hand side
            // sees the pre-edge value, which the slot hand-off relies on.
            used      <= used_nxt;
            req_ready <= (used_nxt < 2'd2);

            rom_rd_en <= accept;
            if (accept) begin
                rom_addr <= ROM_ADDR_W'({req_code, req_row});
            end

            tag_vld[0] <= rom_rd_en;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                tag_vld[i] <= tag_vld[i-1];
            end

            if (pix_fire) begin
                cnt <= release_row ? '0 : cnt + 1'b1;
            end

            // Slot routing. A release hands the spare word to the shift slot
            // on the same edge, so rows follow each other without a bubble;
            // a capture in that cycle then lands wherever space opened up.
            if (release_row) begin
                if (spare_full) begin
                    shift_word <= spare_word;
                    spare_full <= capture;
                    if (capture) begin
                        spare_word <= cap_word;
                    end
                end else begin
                    shift_full <= capture;
                    if (capture) begin
                        shift_word <= cap_word;
                    end
                end
            end else if (capture) begin
                if (!shift_full) begin
                    shift_full <= 1'b1;
                    shift_word <= cap_word;
                end else begin
                    spare_full <= 1'b1;
                    spare_word <= cap_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_osd_glyph_fetch.sv
// -----------------------------------------------------------------------------
// tb_osd_glyph_fetch
//
// Two lanes run in parallel, one DUT with ROM_LATENCY=1 and one with
// ROM_LATENCY=2, each with its own ROM model, stimulus and transaction-level
// reference model. The reference model keeps a queue of accepted rows, each
// ready for output 2+ROM_LATENCY cycles after its request handshake, and
// derives the expected credit-based req_ready, the read strobe and the pixel
// stream from that queue every cycle.
// -----------------------------------------------------------------------------
module tb_osd_glyph_fetch;

`ifdef OSD_GLYPH_INVERT_EN
    localparam bit INV_ON = 1'b1;
`else
    localparam bit INV_ON = 1'b0;
`endif

    typedef struct {
        logic [6:0] code;
        logic [3:0] row;
        logic [7:0] word;
        logic       inv;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        int         avail;
        logic [7:0] bits;
    } row_t;

    logic       clk;
    logic [7:0] rom_mem [0:2047];
    vec_t       vecs [5];
    logic       lane_done [2];
    int         err_cnt = 0;
    int         chk_cnt = 0;

    task automatic check(input int lane, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL lane%0d %s: got 0x%0h expected 0x%0h @%0t",
                     lane, name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int LAT = g + 1;

        logic        rst;
        logic        req_valid;
        logic        req_ready;
        logic [6:0]  req_code;
        logic [3:0]  req_row;
        logic        req_inv;
        logic [10:0] rom_addr;
        logic        rom_rd_en;
        logic [7:0]  rom_rd_data;
        logic        pix_valid;
        logic        pix_ready;
        logic        pix_data;
        logic        pix_last;

        osd_glyph_fetch #(
            .CODE_W(7), .ROW_W(4), .ROM_ADDR_W(11), .GLYPH_W(8), .ROM_LATENCY(LAT)
        ) u_dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid), .req_ready(req_ready),
            .req_code(req_code), .req_row(req_row), .req_inv(req_inv),
            .rom_addr(rom_addr), .rom_rd_en(rom_rd_en), .rom_rd_data(rom_rd_data),
            .pix_valid(pix_valid), .pix_ready(pix_ready),
            .pix_data(pix_data), .pix_last(pix_last)
        );

        // ROM model: output register loads on the strobe; otherwise it shows
        // junk so a capture in the wrong cycle is visible.
        logic [7:0] q1, q2;
        always @(posedge clk) begin
            q1 <= rom_rd_en ? rom_mem[rom_addr] : 8'($urandom);
            q2 <= q1;
        end
        assign rom_rd_data = (LAT == 1) ? q1 : q2;

        // ---------------- reference model / scoreboard ----------------
        row_t        rows [$];
        row_t        new_row;
        int          cyc = 0;
        int          bidx = 0;
        int          used = 0;
        logic        armed = 1'b0;
        logic        exp_rd = 1'b0;
        logic [10:0] exp_addr = '0;
        logic        ev, acc, rel;

        always @(negedge clk) begin
            if (rst) begin
                check(g, "rst req_ready", req_ready, 0);
                check(g, "rst rom_rd_en", rom_rd_en, 0);
                check(g, "rst pix_valid", pix_valid, 0);
                rows.delete();
                bidx   = 0;
                used   = 0;
                armed  = 1'b0;
                exp_rd = 1'b0;
            end else begin
                check(g, "req_ready", req_ready, (armed && used < 2) ? 1 : 0);
                check(g, "rom_rd_en", rom_rd_en, exp_rd);
                if (exp_rd) check(g, "rom_addr", rom_addr, exp_addr);
                ev = (rows.size() > 0) && (cyc >= rows[0].avail);
                check(g, "pix_valid", pix_valid, ev);
                rel = 1'b0;
                if (ev) begin
                    check(g, "pix_data", pix_data, rows[0].bits[7 - bidx]);
                    check(g, "pix_last", pix_last, (bidx == 7) ? 1 : 0);
                    if (pix_ready) begin
                        bidx++;
                        if (bidx == 8) begin
                            void'(rows.pop_front());
                            bidx = 0;
                            rel  = 1'b1;
                        end
                    end
                end
                acc      = req_valid && req_ready;
                exp_rd   = acc;
                exp_addr = {req_code, req_row};
                if (acc) begin
                    new_row.avail = cyc + 2 + LAT;
                    new_row.bits  = rom_mem[{req_code, req_row}]
                                    ^ ((INV_ON && req_inv) ? 8'hFF : 8'h00);
                    rows.push_back(new_row);
                end
                used  = used + int'(acc) - int'(rel);
                armed = 1'b1;
            end
            cyc++;
        end

        // ---------------- stimulus ----------------
        task automatic tick();
            @(posedge clk);
            #1;
        endtask

        // Wait (bounded) for req_ready, then complete one handshake.
        task automatic send(input logic [6:0] code, input logic [3:0] row,
                            input logic inv);
            int n = 0;
            req_code  = code;
            req_row   = row;
            req_inv   = inv;
            req_valid = 1'b1;
            while (!req_ready && n < 40) begin
                tick();
                n++;
            end
            check(g, "req_ready wait", req_ready, 1);
            tick();
            req_valid = 1'b0;
        endtask

        task automatic run_vec(input vec_t v);
            int         first = -1;
            int         last_at = -1;
            int         nv = 0;
            int         extra_rd = 0;
            logic [7:0] bits = '0;
            pix_ready = 1'b1;
            send(v.code, v.row, v.inv);
            // Now in T+1.
            check(g, "vec rd_en T+1", rom_rd_en, 1);
            check(g, "vec rom_addr", rom_addr, {v.code, v.row});
            for (int off = 1; off < LAT + 13; off++) begin
                if (rom_rd_en && off != 1) extra_rd++;
                if (pix_valid) begin
                    if (first < 0) first = off;
                    bits = {bits[6:0], pix_data};
                    nv++;
                    if (pix_last) last_at = off;
                end
                tick();
            end
            check(g, "vec extra rd_en", extra_rd, 0);
            check(g, "vec first valid", first, 2 + LAT);
            check(g, "vec valid count", nv, 8);
            check(g, "vec bits", bits, v.exp);
            check(g, "vec last at", last_at, 9 + LAT);
        endtask

        initial begin : stim
            int   nacc, nv, nl, fv, lv, n;
            logic hs, hold_d, hold_l, stable, busy;

            rst       = 1'b1;
            req_valid = 1'b0;
            req_code  = '0;
            req_row   = '0;
            req_inv   = 1'b0;
            pix_ready = 1'b0;
            repeat (3) tick();
            check(g, "reset req_ready", req_ready, 0);
            check(g, "reset rom_addr", rom_addr, 0);
            check(g, "reset rom_rd_en", rom_rd_en, 0);
            check(g, "reset pix_valid", pix_valid, 0);
            check(g, "reset pix_data", pix_data, 0);
            check(g, "reset pix_last", pix_last, 0);
            rst = 1'b0;
            check(g, "ready before first edge", req_ready, 0);
            tick();
            check(g, "ready after release", req_ready, 1);

            // Table-driven single requests.
            for (int i = 0; i < 5; i++) begin
                run_vec(vecs[i]);
            end

            // Four back-to-back requests with req_valid held.
            nacc = 0; nv = 0; nl = 0; fv = -1; lv = -1;
            pix_ready = 1'b1;
            for (int c = 0; c < 70; c++) begin
                if (nacc < 4) begin
                    req_valid = 1'b1;
                    req_code  = vecs[nacc].code;
                    req_row   = vecs[nacc].row;
                    req_inv   = vecs[nacc].inv;
                end else begin
                    req_valid = 1'b0;
                end
                if (pix_valid) begin
                    if (fv < 0) fv = c;
                    lv = c;
                    nv++;
                    if (pix_last) nl++;
                end
                hs = req_valid && req_ready;
                tick();
                if (hs) nacc++;
            end
            req_valid = 1'b0;
            check(g, "b2b accepted", nacc, 4);
            check(g, "b2b valid cycles", nv, 32);
            check(g, "b2b contiguous span", lv - fv + 1, 32);
            check(g, "b2b last pulses", nl, 4);

            // Two requests, then stall the pixel side mid-row.
            send(vecs[0].code, vecs[0].row, 1'b0);
            send(vecs[2].code, vecs[2].row, 1'b0);
            n = 0;
            while (!pix_valid && n < 20) begin
                tick();
                n++;
            end
            check(g, "stall first valid", pix_valid, 1);
            repeat (3) tick();
            pix_ready = 1'b0;
            req_valid = 1'b1;
            req_code  = vecs[4].code;
            req_row   = vecs[4].row;
            req_inv   = 1'b0;
            hold_d = pix_data;
            hold_l = pix_last;
            check(g, "stall held bit", hold_d, vecs[0].word[4]);
            stable = 1'b1;
            busy   = 1'b0;
            for (int c = 0; c < 20; c++) begin
                tick();
                if (pix_valid !== 1'b1 || pix_data !== hold_d || pix_last !== hold_l)
                    stable = 1'b0;
                if (req_ready !== 1'b0 || rom_rd_en !== 1'b0) busy = 1'b1;
            end
            check(g, "stall outputs stable", stable, 1);
            check(g, "stall no credit/read", busy, 0);
            pix_ready = 1'b1;
            send(vecs[4].code, vecs[4].row, 1'b0);
            repeat (40) tick();

            // Reset one cycle after the read strobe.
            send(vecs[0].code, vecs[0].row, 1'b0);
            check(g, "mid rd_en", rom_rd_en, 1);
            tick();
            rst = 1'b1;
            #1;
            check(g, "mid rst req_ready", req_ready, 0);
            check(g, "mid rst rom_addr", rom_addr, 0);
            check(g, "mid rst rom_rd_en", rom_rd_en, 0);
            check(g, "mid rst pix_valid", pix_valid, 0);
            check(g, "mid rst pix_data", pix_data, 0);
            check(g, "mid rst pix_last", pix_last, 0);
            repeat (2) tick();
            rst = 1'b0;
            tick();
            run_vec(vecs[4]);

            // Randomized traffic against the reference model.
            hs = 1'b0;
            for (int c = 0; c < 400; c++) begin
                if (!req_valid || hs) begin
                    req_valid = ($urandom % 3) != 0;
                    req_code  = 7'($urandom);
                    req_row   = 4'($urandom);
                    req_inv   = 1'($urandom);
                end
                pix_ready = ($urandom % 4) != 0;
                hs = req_valid && req_ready;
                tick();
            end
            req_valid = 1'b0;
            pix_ready = 1'b1;
            repeat (60) tick();
            check(g, "drained", pix_valid, 0);
            lane_done[g] = 1'b1;
        end
    end

    initial begin
        lane_done[0] = 1'b0;
        lane_done[1] = 1'b0;
        vecs[0] = '{code: 7'h41, row: 4'h3, word: 8'hA5, inv: 1'b0, exp: 8'hA5};
        vecs[1] = '{code: 7'h41, row: 4'h3, word: 8'hA5, inv: 1'b1,
                    exp: INV_ON ? 8'h5A : 8'hA5};
        vecs[2] = '{code: 7'h00, row: 4'h0, word: 8'h80, inv: 1'b0, exp: 8'h80};
        vecs[3] = '{code: 7'h7F, row: 4'hF, word: 8'h01, inv: 1'b1,
                    exp: INV_ON ? 8'hFE : 8'h01};
        vecs[4] = '{code: 7'h30, row: 4'h0, word: 8'hFF, inv: 1'b0, exp: 8'hFF};
        for (int a = 0; a < 2048; a++) rom_mem[a] = 8'($urandom);
        for (int i = 0; i < 5; i++) rom_mem[{vecs[i].code, vecs[i].row}] = vecs[i].word;

        for (int c = 0; c < 20000 && !(lane_done[0] && lane_done[1]); c++) begin
            @(posedge clk);
        end
        check(0, "lanes finished", {lane_done[0], lane_done[1]}, 2'b11);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
